// File: rtl/demux1_4_key.sv
// demux1_4_key: registered 1-to-4 demultiplexer with push-button lane select.
// din is steered onto one of four output lanes; all other lanes hold IDLE_VAL.
// A debounced press of key_in (active-low) advances the active lane 0->1->2->3->0.
// Optional feature macro: DEMUX_ONEHOT_IND_EN adds the sel_led output, an
// active-low one-hot copy of the lane index, registered alongside sel_out.
module demux1_4_key #(
    parameter int unsigned CNT_MAX  = 32'd999_999,
    parameter int unsigned DATA_W   = 32'd1,
    parameter logic        IDLE_VAL = 1'b1
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst_n,
    input  logic                  key_in,
    input  logic [DATA_W-1:0]     din,
    output logic [4*DATA_W-1:0]   dout,
`ifdef DEMUX_ONEHOT_IND_EN
    output logic [3:0]            sel_led,
`endif
    output logic [1:0]            sel_out
);

    localparam int unsigned      CNT_W   = $clog2(CNT_MAX + 32'd1);
    localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(CNT_MAX);
    localparam logic [CNT_W-1:0] CNT_PRE = CNT_W'(CNT_MAX - 32'd1);

    typedef enum logic [1:0] {
        CH0 = 2'd0,
        CH1 = 2'd1,
        CH2 = 2'd2,
        CH3 = 2'd3
    } state_t;

    logic             key_meta_r;
    logic             key_sync_r;
    logic [CNT_W-1:0] cnt_r;
    logic             press_flag_s;
    state_t           state_r;
    state_t           state_next_s;
    logic [4*DATA_W-1:0] dout_next_s;

    // Two-flop synchroniser for the asynchronous push-button; idles released (1).
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            key_meta_r <= 1'b1;
            key_sync_r <= 1'b1;
        end else begin
            key_meta_r <= key_in;
            key_sync_r <= key_meta_r;
        end
    end

    // Debounce counter: cleared while released, counts up and saturates while pressed.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (key_sync_r) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (cnt_r != CNT_TOP) begin
            cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Single-cycle press pulse; saturation stops it repeating while the key is held.
    always_comb begin
        press_flag_s = 1'b0;
        if (!key_sync_r && (cnt_r == CNT_PRE)) begin
            press_flag_s = 1'b1;
        end else begin
            press_flag_s = 1'b0;
        end
    end

    // Lane FSM next state: advance one lane per press, wrapping CH3 back to CH0.
    always_comb begin
        state_next_s = state_r;
        if (press_flag_s) begin
            case (state_r)
                CH0:     state_next_s = CH1;
                CH1:     state_next_s = CH2;
                CH2:     state_next_s = CH3;
                CH3:     state_next_s = CH0;
                default: state_next_s = CH0;
            endcase
        end else begin
            state_next_s = state_r;
        end
    end

    // Lane FSM state register.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_r <= CH0;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Output lane image from the current (pre-edge) lane, so a lane switch never
    // shows two active lanes or a gap with none.
    always_comb begin
        dout_next_s = {(4*DATA_W){IDLE_VAL}};
        for (int i = 0; i < 4; i++) begin
            if (state_r == 2'(i)) begin
                dout_next_s[i*DATA_W +: DATA_W] = din;
            end else begin
                dout_next_s[i*DATA_W +: DATA_W] = {DATA_W{IDLE_VAL}};
            end
        end
    end

    // Registered data outputs.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            dout <= {(4*DATA_W){IDLE_VAL}};
        end else begin
            dout <= dout_next_s;
        end
    end

    assign sel_out = state_r;

`ifdef DEMUX_ONEHOT_IND_EN
    // Active-low one-hot lane indicator, loaded from next state to track sel_out.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sel_led <= 4'b1110;
        end else begin
            sel_led <= ~(4'b0001 << state_next_s);
        end
    end
`endif

endmodule
